mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control_if.sv | 37 +++
 rtl/mc_control.sv | 243 ++++++++++++++++++++++++
 tb/tb_mc_control.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_if.sv
// Control/status bundle between mc_control (master) and its datapath (slave).
interface mc_control_if #(
  parameter int unsigned INSTRUCTION = 32
) ();
  localparam int unsigned IMM_SEL_W = 2;
  localparam int unsigned ALU_CTRL_W = 4;

  logic [INSTRUCTION-1:0] instruction;
  logic                   imem_ack;
  logic                   dmem_ack;
  logic                   br_taken;

  logic                   imem_req;
  logic                   ir_en;
  logic                   pc_en;
  logic                   pc_src;
  logic [IMM_SEL_W-1:0]   imm_sel;
  logic                   alu_src_imm;
  logic [ALU_CTRL_W-1:0]  alu_ctrl;
  logic                   dmem_req;
  logic                   dmem_we;
  logic                   reg_we;
  logic                   wb_sel;
  logic                   illegal;

  modport master (
    input  instruction, imem_ack, dmem_ack, br_taken,
    output imem_req, ir_en, pc_en, pc_src, imm_sel, alu_src_imm, alu_ctrl,
           dmem_req, dmem_we, reg_we, wb_sel, illegal
  );

  modport slave (
    output instruction, imem_ack, dmem_ack, br_taken,
    input  imem_req, ir_en, pc_en, pc_src, imm_sel, alu_src_imm, alu_ctrl,
           dmem_req, dmem_we, reg_we, wb_sel, illegal
  );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle RV32 subset control FSM (R/I/load/store/branch).
// Define MC_CONTROL_TRAP_EN to trap on illegal opcodes; otherwise they retire as NOPs.
module mc_control #(
  parameter int unsigned INSTRUCTION = 32
) (
  input  logic         clk,
  input  logic         rst,
  mc_control_if.master bus
);
  localparam int unsigned OPC_W      = 7;
  localparam int unsigned F3_W       = 3;
  localparam int unsigned IMM_SEL_W  = 2;
  localparam int unsigned ALU_CTRL_W = 4;

  localparam logic [OPC_W-1:0] OPC_R = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_I = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_L = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_S = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_B = 7'b1100011;

  localparam logic [F3_W-1:0] F3_SHIFT_RIGHT = 3'b101;

  localparam logic [IMM_SEL_W-1:0] IMM_I = 2'b00;
  localparam logic [IMM_SEL_W-1:0] IMM_S = 2'b01;
  localparam logic [IMM_SEL_W-1:0] IMM_B = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB
`ifdef MC_CONTROL_TRAP_EN
    , S_TRAP
`endif
  } state_e;

  typedef enum logic [2:0] {
    C_NONE,
    C_R,
    C_I,
    C_L,
    C_S,
    C_B,
    C_ILL
  } cls_e;

  state_e state_q, state_d;
  cls_e   cls_q, cls_d;

  logic [INSTRUCTION-1:0] instr;
  logic [OPC_W-1:0]       opcode;
  logic [F3_W-1:0]        funct3;
  logic                   f7b5_bit;
  logic                   unused_instr;

  cls_e                   cls_dec;
  cls_e                   cls_eff;

  logic [IMM_SEL_W-1:0]   imm_sel_dec_c;
  logic                   alu_src_dec_c;
  logic [ALU_CTRL_W-1:0]  alu_ctrl_dec_c;

  logic                   imem_req_c;
  logic                   ir_en_c;
  logic                   pc_en_c;
  logic                   pc_src_c;
  logic [IMM_SEL_W-1:0]   imm_sel_c;
  logic                   alu_src_imm_c;
  logic [ALU_CTRL_W-1:0]  alu_ctrl_c;
  logic                   dmem_req_c;
  logic                   dmem_we_c;
  logic                   reg_we_c;
  logic                   wb_sel_c;
  logic                   illegal_c;

  assign instr        = bus.instruction;
  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign f7b5_bit     = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // Opcode classifier; only meaningful while the IR is stable (DECODE onward).
  always_comb begin
    cls_dec = C_ILL;
    case (opcode)
      OPC_R:   cls_dec = C_R;
      OPC_I:   cls_dec = C_I;
      OPC_L:   cls_dec = C_L;
      OPC_S:   cls_dec = C_S;
      OPC_B:   cls_dec = C_B;
      default: cls_dec = C_ILL;
    endcase
  end

  // The class register is loaded at the end of DECODE, so DECODE itself uses the live decode.
  assign cls_eff = (state_q == S_DECODE) ? cls_dec : cls_q;

  // Operand/ALU selects per class; gated by state in the FSM below.
  always_comb begin
    imm_sel_dec_c  = IMM_I;
    alu_src_dec_c  = 1'b0;
    alu_ctrl_dec_c = '0;
    case (cls_eff)
      C_R: alu_ctrl_dec_c = {f7b5_bit, funct3};
      C_I: begin
        alu_src_dec_c  = 1'b1;
        alu_ctrl_dec_c = {(funct3 == F3_SHIFT_RIGHT) & f7b5_bit, funct3};
      end
      C_L: alu_src_dec_c = 1'b1;
      C_S: begin
        imm_sel_dec_c = IMM_S;
        alu_src_dec_c = 1'b1;
      end
      C_B: begin
        imm_sel_dec_c  = IMM_B;
        alu_ctrl_dec_c = {1'b0, funct3};
      end
      default: ;
    endcase
  end

  // Next-state and control decode.
  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    imem_req_c    = 1'b0;
    ir_en_c       = 1'b0;
    pc_en_c       = 1'b0;
    pc_src_c      = 1'b0;
    imm_sel_c     = '0;
    alu_src_imm_c = 1'b0;
    alu_ctrl_c    = '0;
    dmem_req_c    = 1'b0;
    dmem_we_c     = 1'b0;
    reg_we_c      = 1'b0;
    wb_sel_c      = 1'b0;
    illegal_c     = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        imem_req_c = 1'b1;
        if (bus.imem_ack) begin
          ir_en_c = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        cls_d         = cls_dec;
        imm_sel_c     = imm_sel_dec_c;
        alu_src_imm_c = alu_src_dec_c;
        alu_ctrl_c    = alu_ctrl_dec_c;
        if (cls_dec == C_ILL) begin
`ifdef MC_CONTROL_TRAP_EN
          state_d = S_TRAP;
`else
          pc_en_c = 1'b1;
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        imm_sel_c     = imm_sel_dec_c;
        alu_src_imm_c = alu_src_dec_c;
        alu_ctrl_c    = alu_ctrl_dec_c;
        case (cls_q)
          C_R, C_I: state_d = S_WB;
          C_L, C_S: state_d = S_MEM;
          C_B: begin
            pc_en_c  = 1'b1;
            pc_src_c = bus.br_taken;
            state_d  = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        imm_sel_c     = imm_sel_dec_c;
        alu_src_imm_c = alu_src_dec_c;
        alu_ctrl_c    = alu_ctrl_dec_c;
        dmem_req_c    = 1'b1;
        dmem_we_c     = (cls_q == C_S);
        // PC advances only on the ack cycle so a stalled store still yields a single pc_en.
        if (bus.dmem_ack) begin
          if (cls_q == C_L) begin
            state_d = S_WB;
          end else begin
            pc_en_c = 1'b1;
            state_d = S_FETCH;
          end
        end
      end

      S_WB: begin
        imm_sel_c     = imm_sel_dec_c;
        alu_src_imm_c = alu_src_dec_c;
        alu_ctrl_c    = alu_ctrl_dec_c;
        reg_we_c      = 1'b1;
        wb_sel_c      = (cls_q == C_L);
        pc_en_c       = 1'b1;
        state_d       = S_FETCH;
      end

`ifdef MC_CONTROL_TRAP_EN
      S_TRAP: illegal_c = 1'b1;
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // State and class registers; reset forces IDLE, which zeroes every output at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_q   <= C_NONE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  assign bus.imem_req    = imem_req_c;
  assign bus.ir_en       = ir_en_c;
  assign bus.pc_en       = pc_en_c;
  assign bus.pc_src      = pc_src_c;
  assign bus.imm_sel     = imm_sel_c;
  assign bus.alu_src_imm = alu_src_imm_c;
  assign bus.alu_ctrl    = alu_ctrl_c;
  assign bus.dmem_req    = dmem_req_c;
  assign bus.dmem_we     = dmem_we_c;
  assign bus.reg_we      = reg_we_c;
  assign bus.wb_sel      = wb_sel_c;
  assign bus.illegal     = illegal_c;
endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control. Output vector field order:
// imem_req ir_en pc_en pc_src imm_sel[1:0] alu_src_imm alu_ctrl[3:0] dmem_req dmem_we reg_we wb_sel illegal
module tb_mc_control;
  logic        clk;
  logic        rst;
  int unsigned n_vec;
  int unsigned n_err;

  localparam logic [15:0] V_ZERO  = 16'b0_0_0_0_00_0_0000_0_0_0_0_0;
  localparam logic [15:0] V_FET   = 16'b1_1_0_0_00_0_0000_0_0_0_0_0;
  localparam logic [15:0] V_FWAIT = 16'b1_0_0_0_00_0_0000_0_0_0_0_0;
  localparam logic [15:0] V_ADDI  = 16'b0_0_0_0_00_1_0000_0_0_0_0_0;
  localparam logic [15:0] V_ADDIW = 16'b0_0_1_0_00_1_0000_0_0_1_0_0;

  mc_control_if #(.INSTRUCTION(32)) bus ();

  mc_control #(.INSTRUCTION(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] outs();
    return {bus.imem_req, bus.ir_en, bus.pc_en, bus.pc_src, bus.imm_sel, bus.alu_src_imm,
            bus.alu_ctrl, bus.dmem_req, bus.dmem_we, bus.reg_we, bus.wb_sel, bus.illegal};
  endfunction

  task automatic test_reset();
    logic [15:0] got;
    rst             = 1'b1;
    bus.instruction = 32'h00500093;
    bus.imem_ack    = 1'b1;
    bus.dmem_ack    = 1'b1;
    bus.br_taken    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      got = outs(); n_vec++;
      if (got !== V_ZERO) begin n_err++; $display("FAIL reset_hold cyc%0d: got %b want %b", i, got, V_ZERO); end
    end
    @(negedge clk);
    rst          = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.br_taken = 1'b0;
    #1;
    got = outs(); n_vec++;
    if (got !== V_ZERO) begin n_err++; $display("FAIL reset_idle: got %b want %b", got, V_ZERO); end
  endtask

  task automatic test_addi();
    logic [15:0] exp [4];
    logic [15:0] got;
    exp[0] = V_FET; exp[1] = V_ADDI; exp[2] = V_ADDI; exp[3] = V_ADDIW;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.instruction = 32'h00500093;
        bus.imem_ack    = 1'b1;
        bus.dmem_ack    = 1'b0;
        bus.br_taken    = 1'b0;
      end
      #1;
      got = outs(); n_vec++;
      if (got !== exp[i]) begin n_err++; $display("FAIL addi cyc%0d: got %b want %b", i, got, exp[i]); end
    end
  endtask

  task automatic test_sub();
    logic [15:0] exp [4];
    logic [15:0] got;
    exp[0] = V_FET;
    exp[1] = 16'b0_0_0_0_00_0_1000_0_0_0_0_0;
    exp[2] = exp[1];
    exp[3] = 16'b0_0_1_0_00_0_1000_0_0_1_0_0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) bus.instruction = 32'h40B50533;
      #1;
      got = outs(); n_vec++;
      if (got !== exp[i]) begin n_err++; $display("FAIL sub cyc%0d: got %b want %b", i, got, exp[i]); end
    end
  endtask

  // srai keeps bit30 (funct3=101); addi with bit30 set in its immediate must not.
  task automatic test_alu_ctrl();
    logic [31:0] ins [2];
    logic [15:0] exp [8];
    logic [15:0] got;
    ins[0] = 32'h40515093;
    ins[1] = 32'h40000093;
    exp[0] = V_FET;
    exp[1] = 16'b0_0_0_0_00_1_1101_0_0_0_0_0;
    exp[2] = exp[1];
    exp[3] = 16'b0_0_1_0_00_1_1101_0_0_1_0_0;
    exp[4] = V_FET; exp[5] = V_ADDI; exp[6] = V_ADDI; exp[7] = V_ADDIW;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i % 4 == 0) bus.instruction = ins[i / 4];
      #1;
      got = outs(); n_vec++;
      if (got !== exp[i]) begin n_err++; $display("FAIL alu_ctrl cyc%0d: got %b want %b", i, got, exp[i]); end
    end
  endtask

  task automatic test_lw();
    logic [15:0] exp [8];
    logic [15:0] got;
    logic [7:0]  dack;
    dack   = 8'b0100_0011;
    exp[0] = V_FET;
    exp[1] = 16'b0_0_0_0_00_1_0000_0_0_0_0_0;
    exp[2] = exp[1];
    exp[3] = 16'b0_0_0_0_00_1_0000_1_0_0_0_0;
    exp[4] = exp[3]; exp[5] = exp[3]; exp[6] = exp[3];
    exp[7] = 16'b0_0_1_0_00_1_0000_0_0_1_1_0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) bus.instruction = 32'h0000A103;
      bus.dmem_ack = dack[i];
      #1;
      got = outs(); n_vec++;
      if (got !== exp[i]) begin n_err++; $display("FAIL lw cyc%0d: got %b want %b", i, got, exp[i]); end
    end
  endtask

  task automatic test_sw();
    logic [15:0] exp [4];
    logic [15:0] got;
    exp[0] = V_FET;
    exp[1] = 16'b0_0_0_0_01_1_0000_0_0_0_0_0;
    exp[2] = exp[1];
    exp[3] = 16'b0_0_1_0_01_1_0000_1_1_0_0_0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.instruction = 32'h00B52023;
        bus.dmem_ack    = 1'b1;
      end
      #1;
      got = outs(); n_vec++;
      if (got !== exp[i]) begin n_err++; $display("FAIL sw cyc%0d: got %b want %b", i, got, exp[i]); end
    end
  endtask

  task automatic test_beq();
    logic [15:0] exp [3];
    logic [15:0] got;
    for (int b = 1; b >= 0; b--) begin
      exp[0] = V_FET;
      exp[1] = 16'b0_0_0_0_10_0_0000_0_0_0_0_0;
      exp[2] = (b == 1) ? 16'b0_0_1_1_10_0_0000_0_0_0_0_0 : 16'b0_0_1_0_10_0_0000_0_0_0_0_0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (i == 0) begin
          bus.instruction = 32'h00B50463;
          bus.br_taken    = (b == 1);
          bus.dmem_ack    = 1'b0;
        end
        #1;
        got = outs(); n_vec++;
        if (got !== exp[i]) begin n_err++; $display("FAIL beq_br%0d cyc%0d: got %b want %b", b, i, got, exp[i]); end
      end
    end
    bus.br_taken = 1'b0;
  endtask

  task automatic test_illegal();
    logic [15:0] got;
`ifdef MC_CONTROL_TRAP_EN
    logic [15:0] exp [5];
    exp[0] = V_FET; exp[1] = V_ZERO;
    exp[2] = 16'b0_0_0_0_00_0_0000_0_0_0_0_1;
    exp[3] = exp[2]; exp[4] = exp[2];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) bus.instruction = 32'h0000007F;
      bus.dmem_ack = (i >= 2);
      #1;
      got = outs(); n_vec++;
      if (got !== exp[i]) begin n_err++; $display("FAIL illegal_trap cyc%0d: got %b want %b", i, got, exp[i]); end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    got = outs(); n_vec++;
    if (got !== V_ZERO) begin n_err++; $display("FAIL trap_rst: got %b want %b", got, V_ZERO); end
    @(negedge clk);
    rst          = 1'b0;
    bus.dmem_ack = 1'b0;
    #1;
    got = outs(); n_vec++;
    if (got !== V_ZERO) begin n_err++; $display("FAIL trap_rst_idle: got %b want %b", got, V_ZERO); end
`else
    logic [15:0] exp [3];
    exp[0] = V_FET;
    exp[1] = 16'b0_0_1_0_00_0_0000_0_0_0_0_0;
    exp[2] = V_FWAIT;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) bus.instruction = 32'h0000007F;
      bus.imem_ack = (i < 2);
      #1;
      got = outs(); n_vec++;
      if (got !== exp[i]) begin n_err++; $display("FAIL illegal_nop cyc%0d: got %b want %b", i, got, exp[i]); end
    end
`endif
  endtask

  task automatic test_reset_mid_mem();
    logic [15:0] pre [4];
    logic [15:0] post [6];
    logic [15:0] got;
    logic [5:0]  iack;
    pre[0] = V_FET;
    pre[1] = 16'b0_0_0_0_00_1_0000_0_0_0_0_0;
    pre[2] = pre[1];
    pre[3] = 16'b0_0_0_0_00_1_0000_1_0_0_0_0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.instruction = 32'h0000A103;
        bus.imem_ack    = 1'b1;
        bus.dmem_ack    = 1'b0;
      end
      #1;
      got = outs(); n_vec++;
      if (got !== pre[i]) begin n_err++; $display("FAIL rst_mem_pre cyc%0d: got %b want %b", i, got, pre[i]); end
    end
    #1;
    rst          = 1'b1;
    bus.dmem_ack = 1'b1;
    #1;
    got = outs(); n_vec++;
    if (got !== V_ZERO) begin n_err++; $display("FAIL rst_mem_same_cycle: got %b want %b", got, V_ZERO); end
    @(negedge clk); #1;
    got = outs(); n_vec++;
    if (got !== V_ZERO) begin n_err++; $display("FAIL rst_mem_hold: got %b want %b", got, V_ZERO); end
    @(negedge clk);
    rst          = 1'b0;
    bus.imem_ack = 1'b0;
    #1;
    got = outs(); n_vec++;
    if (got !== V_ZERO) begin n_err++; $display("FAIL rst_mem_idle: got %b want %b", got, V_ZERO); end
    // Late dmem_ack stays high; the restarted fetch must wait for imem_ack, then run an addi.
    iack    = 6'b111100;
    post[0] = V_FWAIT; post[1] = V_FWAIT; post[2] = V_FET;
    post[3] = V_ADDI;  post[4] = V_ADDI;  post[5] = V_ADDIW;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) bus.instruction = 32'h00500093;
      bus.imem_ack = iack[i];
      #1;
      got = outs(); n_vec++;
      if (got !== post[i]) begin n_err++; $display("FAIL rst_mem_post cyc%0d: got %b want %b", i, got, post[i]); end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_addi();
    test_sub();
    test_alu_ctrl();
    test_lw();
    test_sw();
    test_beq();
    test_illegal();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
